cc_rst_seq: RTL and testbench
=============================

// Module: cc_rst_seq
// PURPOSE
// - Core-complex reset sequencer between the APB system-config registers and the core complexes.
// - Converts each software reset level (cfg_rst_i) into a core reset with a guaranteed minimum hold time.
// - Latches each core's boot address at release, so later register writes cannot disturb a running core.
// - Arbitrates reset release round-robin: only one core leaves reset per GAP_CYC window,
//   avoiding simultaneous boot fetches into the shared ITCM.
// PARAMETERS
// - N_CC      2   number of core complexes
// - HOLD_CYC  16  minimum cycles core_rst_o stays high per reset episode (>=1)
// - GAP_CYC   8   cycles after a release during which no other release is granted (>=1)
// - CNT_W     $clog2(max(HOLD_CYC,GAP_CYC)+1)  counter width, derived, do not override
// PORTS
// - PCLK              in   1        clock; all logic on rising edge
// - PRESET            in   1        synchronous, active-high reset
// - cfg_rst_i         in   N_CC     per-core software reset level; 1 = hold core in reset
// - cfg_boot_i        in   N_CC*32  per-core boot address; core i at [32*i +: 32]
// - core_idle_i       in   N_CC     core bus idle; used only with CC_RST_QUIESCE_EN, ignored otherwise
// - core_rst_o        out  N_CC     active-high reset to each core complex
// - core_boot_addr_o  out  N_CC*32  boot address latched at release
// - seq_busy_o        out  1        1 while any core is not in RUN, or the gap counter is nonzero
// BEHAVIOUR
// - Clock/reset: one clock (PCLK); reset PRESET is synchronous and active-high.
// - Reset values:
//   - every core FSM in HOLD with hold_cnt = HOLD_CYC
//   - core_rst_o = all 1s; core_boot_addr_o = 0
//   - gap_cnt = 0; rr_ptr = 0; seq_busy_o = 1
// - Per-core FSM, states RUN / QUIESCE / HOLD / WAIT; outputs registered:
//   - HOLD: core_rst_o[i]=1.
//     - hold_cnt decrements to 0 and saturates there.
//     - cfg_rst_i[i]=0 && hold_cnt==0 -> WAIT; otherwise stay.
//   - WAIT: core_rst_o[i]=1; raises req[i].
//     - cfg_rst_i[i]=1 -> HOLD and reload hold_cnt=HOLD_CYC; this takes priority over a same-cycle grant.
//     - grant[i] -> RUN.
//   - RUN: core_rst_o[i]=0.
//     - cfg_rst_i[i]=1 -> HOLD (or QUIESCE if the macro is defined) and reload hold_cnt.
//     - core_rst_o[i] rises 1 cycle after cfg_rst_i rises.
//   - QUIESCE (macro only): core_rst_o[i]=0.
//     - core_idle_i[i]=1 -> HOLD, reload hold_cnt.
//     - cfg_rst_i falling while in QUIESCE does not abort the episode; the reset still completes.
// - Release arbiter:
//   - Grants only when gap_cnt==0; at most one grant per cycle.
//   - Round-robin search starts at rr_ptr and wraps N_CC-1 -> 0.
//   - On a grant to core i:
//     - core_boot_addr_o[i] <= cfg_boot_i[i] in the grant cycle.
//     - core_rst_o[i] <= 0 in the same edge.
//     - gap_cnt <= GAP_CYC; rr_ptr <= (i+1) mod N_CC.
//   - gap_cnt decrements to 0 and saturates there.
// - core_boot_addr_o[i] is stable for the whole RUN/QUIESCE interval and is never updated outside a grant.
// - Minimum latency from cfg_rst_i falling to core release: HOLD_CYC cycles in HOLD, +1 cycle in WAIT.
// - Simultaneous WAIT requests are released GAP_CYC+1 cycles apart, in rr order.
// - PRESET mid-operation returns every core to HOLD regardless of state; an in-progress gap is cleared.
// CONFIGURATION
// - CC_RST_QUIESCE_EN defined:
//   - A RUN -> reset request goes through QUIESCE and waits for core_idle_i[i] before asserting core_rst_o.
//   - No timeout; software must ensure the core reaches idle.
// - CC_RST_QUIESCE_EN undefined:
//   - The QUIESCE state and its logic are absent; RUN goes directly to HOLD.
//   - core_idle_i is unused (tie off).
// TESTING (N_CC=2, HOLD_CYC=16, GAP_CYC=8)
// - Power-on, cfg_rst_i=00, cfg_boot_i={0x8000_1000,0x8000_0000}:
//   - core0 released at cycle 17 after PRESET deassert, core1 at 26.
//   - Boot addresses 0x8000_0000 and 0x8000_1000 respectively.
// - Core0 in RUN, pulse cfg_rst_i[0] for 1 cycle:
//   - core_rst_o[0] high next cycle for exactly 17 cycles.
//   - Then released with the current cfg_boot_i[0].
// - Change cfg_boot_i[1] to 0x1234_5678 while core1 runs:
//   - core_boot_addr_o[1] unchanged until core1's next release.
// - Both cores held, cfg_rst_i 11 -> 00 same cycle, rr_ptr=1:
//   - core1 released first, core0 9 cycles later; rr_ptr ends at 1.
// - cfg_rst_i[0] re-asserted in the same cycle core0 is in WAIT with a pending grant:
//   - no release; hold_cnt reloads to 16.
// - With CC_RST_QUIESCE_EN, core_idle_i[0]=0 for 20 cycles after cfg_rst_i[0] rises:
//   - core_rst_o[0] stays 0 for those 20 cycles.
//   - Rises the cycle after core_idle_i[0]=1.

Source files
------------

// File: rtl/cc_rst_seq.sv
// Core-complex reset sequencer.
// Turns each software reset level into a core reset with a minimum hold time.
// Captures each core's boot address when that core is released.
// Releases cores one at a time, round-robin, spaced at least GAP_CYC cycles apart.
//
// Optional feature macro: CC_RST_QUIESCE_EN
//   defined   : RUN -> QUIESCE, wait for core_idle_i, then HOLD
//   undefined : RUN -> HOLD directly; core_idle_i is ignored
//
// Ports
//   PCLK              clock, rising edge
//   PRESET            synchronous active-high reset
//   cfg_rst_i         per-core software reset level (1 = hold in reset)
//   cfg_boot_i        per-core boot address, core i at [32*i +: 32]
//   core_idle_i       per-core bus idle (quiesce build only)
//   core_rst_o        per-core active-high reset
//   core_boot_addr_o  per-core boot address captured at release
//   seq_busy_o        1 while any core is not in RUN or a release gap is open
module cc_rst_seq #(
    parameter int unsigned N_CC     = 2,
    parameter int unsigned HOLD_CYC = 16,
    parameter int unsigned GAP_CYC  = 8
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [N_CC-1:0]    cfg_rst_i,
    input  logic [N_CC*32-1:0] cfg_boot_i,
    input  logic [N_CC-1:0]    core_idle_i,
    output logic [N_CC-1:0]    core_rst_o,
    output logic [N_CC*32-1:0] core_boot_addr_o,
    output logic               seq_busy_o
);

    localparam int unsigned MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned PTR_W   = (N_CC > 1) ? $clog2(N_CC) : 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
`ifdef CC_RST_QUIESCE_EN
        ST_QUIESCE = 2'd1,
`endif
        ST_HOLD    = 2'd2,
        ST_WAIT    = 2'd3
    } cc_state_e;

    logic [N_CC-1:0]    req;
    logic [N_CC-1:0]    grant;
    logic [N_CC-1:0]    rst_d;
    logic [N_CC-1:0]    not_run_d;
    logic [N_CC*32-1:0] boot_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic               busy_d;

`ifndef CC_RST_QUIESCE_EN
    logic unused_idle;
    assign unused_idle = ^core_idle_i;
`endif

    // Round-robin release arbiter and inter-release gap timer
    always_comb begin
        int unsigned sum;
        int unsigned nxt;
        logic [PTR_W-1:0] idx;
        logic             found;
        sum   = 0;
        nxt   = 0;
        idx   = '0;
        found = 1'b0;
        grant = '0;
        rr_d  = rr_q;
        gap_d = (gap_q != '0) ? gap_q - CNT_W'(1) : '0;
        if (gap_q == '0) begin
            for (int unsigned k = 0; k < N_CC; k++) begin
                sum = 32'(rr_q) + k;
                if (sum >= N_CC) begin
                    sum = sum - N_CC;
                end
                idx = PTR_W'(sum);
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    gap_d      = CNT_W'(GAP_CYC);
                    nxt        = sum + 1;
                    if (nxt >= N_CC) begin
                        nxt = 0;
                    end
                    rr_d = PTR_W'(nxt);
                end
            end
        end
    end

    for (genvar g = 0; g < N_CC; g++) begin : g_core
        cc_state_e        state_q, state_d;
        logic [CNT_W-1:0] hold_q, hold_d;

        // A same-cycle reset request masks the request, so it beats any grant
        assign req[g] = (state_q == ST_WAIT) && !cfg_rst_i[g];

        // Per-core state register
        always_ff @(posedge PCLK) begin
            if (PRESET) begin
                state_q <= ST_HOLD;
                hold_q  <= CNT_W'(HOLD_CYC);
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
            end
        end

        // Per-core next state; hold_cnt counts HOLD cycles still owed,
        // so the exit test uses the post-decrement value
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            case (state_q)
                ST_HOLD: begin
                    hold_d = (hold_q != '0) ? hold_q - CNT_W'(1) : '0;
                    if (!cfg_rst_i[g] && (hold_d == '0)) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cfg_rst_i[g]) begin
                        state_d = ST_HOLD;
                        hold_d  = CNT_W'(HOLD_CYC);
                    end else if (grant[g]) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cfg_rst_i[g]) begin
`ifdef CC_RST_QUIESCE_EN
                        state_d = ST_QUIESCE;
`else
                        state_d = ST_HOLD;
                        hold_d  = CNT_W'(HOLD_CYC);
`endif
                    end
                end
`ifdef CC_RST_QUIESCE_EN
                ST_QUIESCE: begin
                    // Once started, the episode completes even if cfg_rst_i drops
                    if (core_idle_i[g]) begin
                        state_d = ST_HOLD;
                        hold_d  = CNT_W'(HOLD_CYC);
                    end
                end
`endif
                default: begin
                    state_d = ST_HOLD;
                    hold_d  = CNT_W'(HOLD_CYC);
                end
            endcase
        end

        assign rst_d[g]     = (state_d == ST_HOLD) || (state_d == ST_WAIT);
        assign not_run_d[g] = (state_d != ST_RUN);
        assign boot_d[32*g +: 32] = grant[g] ? cfg_boot_i[32*g +: 32]
                                             : core_boot_addr_o[32*g +: 32];
    end

    assign busy_d = (|not_run_d) || (gap_d != '0);

    // Shared arbiter state and registered outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            gap_q            <= '0;
            rr_q             <= '0;
            core_rst_o       <= '1;
            core_boot_addr_o <= '0;
            seq_busy_o       <= 1'b1;
        end else begin
            gap_q            <= gap_d;
            rr_q             <= rr_d;
            core_rst_o       <= rst_d;
            core_boot_addr_o <= boot_d;
            seq_busy_o       <= busy_d;
        end
    end

endmodule

// File: tb/tb_cc_rst_seq.sv
// Testbench for cc_rst_seq: directed release-timing scenarios followed by
// random reset/boot/idle/PRESET traffic, all checked against a timestamp model.
module tb_cc_rst_seq;

    localparam int unsigned N_CC     = 2;
    localparam int unsigned HOLD_CYC = 16;
    localparam int unsigned GAP_CYC  = 8;

    localparam int M_RUN  = 0;
    localparam int M_QUI  = 1;
    localparam int M_HOLD = 2;
    localparam int M_WAIT = 3;

    logic               PCLK;
    logic               PRESET;
    logic [N_CC-1:0]    cfg_rst_i;
    logic [N_CC*32-1:0] cfg_boot_i;
    logic [N_CC-1:0]    core_idle_i;
    logic [N_CC-1:0]    core_rst_o;
    logic [N_CC*32-1:0] core_boot_addr_o;
    logic               seq_busy_o;

    cc_rst_seq #(.N_CC(N_CC), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC)) dut (
        .PCLK             (PCLK),
        .PRESET           (PRESET),
        .cfg_rst_i        (cfg_rst_i),
        .cfg_boot_i       (cfg_boot_i),
        .core_idle_i      (core_idle_i),
        .core_rst_o       (core_rst_o),
        .core_boot_addr_o (core_boot_addr_o),
        .seq_busy_o       (seq_busy_o)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: each core's mode, the edge at which its hold began,
    // and the edge of the most recent release.
    int          mode    [N_CC];
    int          hold_at [N_CC];
    logic [31:0] eboot   [N_CC];
    int          edge_n  = 0;
    int          last_g  = 0;
    bit          have_g  = 1'b0;
    int          rr      = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_step();
        bit [N_CC-1:0] ready;
        int g;
        int j;
        edge_n++;
        if (PRESET) begin
            for (int i = 0; i < N_CC; i++) begin
                mode[i]    = M_HOLD;
                hold_at[i] = edge_n;
                eboot[i]   = '0;
            end
            have_g = 1'b0;
            rr     = 0;
            return;
        end
        g = -1;
        for (int i = 0; i < N_CC; i++) ready[i] = (mode[i] == M_WAIT) && !cfg_rst_i[i];
        if (!have_g || (edge_n - last_g > int'(GAP_CYC))) begin
            for (int k = 0; k < N_CC; k++) begin
                j = (rr + k) % N_CC;
                if (g < 0 && ready[j]) g = j;
            end
        end
        if (g >= 0) begin
            have_g = 1'b1;
            last_g = edge_n;
            rr     = (g + 1) % N_CC;
        end
        for (int i = 0; i < N_CC; i++) begin
            case (mode[i])
                M_HOLD: if (!cfg_rst_i[i] && (edge_n - hold_at[i] >= int'(HOLD_CYC))) mode[i] = M_WAIT;
                M_WAIT: begin
                    if (cfg_rst_i[i]) begin
                        mode[i] = M_HOLD;
                        hold_at[i] = edge_n;
                    end else if (g == i) begin
                        mode[i]  = M_RUN;
                        eboot[i] = cfg_boot_i[32*i +: 32];
                    end
                end
                M_RUN: begin
                    if (cfg_rst_i[i]) begin
`ifdef CC_RST_QUIESCE_EN
                        mode[i] = M_QUI;
`else
                        mode[i] = M_HOLD;
                        hold_at[i] = edge_n;
`endif
                    end
                end
                default: begin
                    if (core_idle_i[i]) begin
                        mode[i] = M_HOLD;
                        hold_at[i] = edge_n;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        bit busy;
        busy = have_g && (edge_n - last_g < int'(GAP_CYC));
        for (int i = 0; i < N_CC; i++) begin
            chk($sformatf("core_rst[%0d]", i), 64'(core_rst_o[i]),
                64'((mode[i] == M_HOLD) || (mode[i] == M_WAIT)));
            chk($sformatf("boot[%0d]", i), 64'(core_boot_addr_o[32*i +: 32]), 64'(eboot[i]));
            if (mode[i] != M_RUN) busy = 1'b1;
        end
        chk("busy", 64'(seq_busy_o), 64'(busy));
    endtask

    task automatic cycle();
        @(posedge PCLK);
        model_step();
        @(negedge PCLK);
        compare_all();
    endtask

    // First cycle (1-based) at which each core leaves reset, -1 if never
    task automatic measure_pair(output int r0, output int r1);
        r0 = -1;
        r1 = -1;
        for (int c = 1; c <= 60; c++) begin
            cycle();
            if (r0 < 0 && !core_rst_o[0]) r0 = c;
            if (r1 < 0 && !core_rst_o[1]) r1 = c;
        end
    endtask

    // Cycles until the given core leaves reset, bounded
    task automatic wait_rel(input int idx, output int n);
        n = 0;
        while (core_rst_o[idx] && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) chk("release_timeout", 64'(n), 64'(0));
    endtask

    task automatic pulse(input int idx);
        cfg_rst_i[idx] = 1'b1;
        cycle();
        cfg_rst_i[idx] = 1'b0;
    endtask

    initial begin
        int rel0, rel1, n;
        PRESET      = 1'b1;
        cfg_rst_i   = '0;
        core_idle_i = '1;
        cfg_boot_i  = {32'h8000_1000, 32'h8000_0000};
        cycle();
        cycle();
        chk("reset_rst", 64'(core_rst_o), 64'(2'b11));
        chk("reset_boot", 64'(core_boot_addr_o), 64'(0));
        chk("reset_busy", 64'(seq_busy_o), 64'(1));
        PRESET = 1'b0;

        // Power-on release order and timing
        measure_pair(rel0, rel1);
        chk("poweron_rel0", 64'(rel0), 64'(17));
        chk("poweron_rel1", 64'(rel1), 64'(26));
        chk("poweron_boot0", 64'(core_boot_addr_o[31:0]), 64'(32'h8000_0000));
        chk("poweron_boot1", 64'(core_boot_addr_o[63:32]), 64'(32'h8000_1000));

        // One-cycle reset pulse on core0, new boot address picked up at release
        cfg_boot_i[31:0] = 32'hA5A5_0000;
        pulse(0);
        n = core_rst_o[0] ? 1 : 0;
        for (int k = 0; k < 100 && core_rst_o[0]; k++) begin
            cycle();
            if (core_rst_o[0]) n++;
        end
        chk("pulse_hold_len", 64'(n), 64'(17));
        chk("pulse_boot0", 64'(core_boot_addr_o[31:0]), 64'(32'hA5A5_0000));

        // Boot register changes while running do not reach the core
        cfg_boot_i[63:32] = 32'h1234_5678;
        repeat (20) cycle();
        chk("boot1_stable", 64'(core_boot_addr_o[63:32]), 64'(32'h8000_1000));
        pulse(1);
        wait_rel(1, n);
        chk("boot1_new", 64'(core_boot_addr_o[63:32]), 64'(32'h1234_5678));

        // Make core0 the last grantee so the pointer sits on core1
        pulse(0);
        wait_rel(0, n);
        repeat (10) cycle();
        cfg_rst_i = 2'b11;
        repeat (20) cycle();
        cfg_rst_i = 2'b00;
        measure_pair(rel0, rel1);
        chk("rr_first_core1", 64'(rel1), 64'(2));
        chk("rr_core0_gap", 64'(rel0 - rel1), 64'(GAP_CYC + 1));
        cfg_rst_i = 2'b11;
        repeat (20) cycle();
        cfg_rst_i = 2'b00;
        measure_pair(rel0, rel1);
        chk("rr_again_core1", 64'(rel1), 64'(2));
        chk("rr_again_core0", 64'(rel0), 64'(11));

        // Reset re-asserted in the cycle a WAIT core would have been granted
        pulse(0);
        repeat (16) cycle();
        cfg_rst_i[0] = 1'b1;
        cycle();
        chk("wait_abort_norel", 64'(core_rst_o[0]), 64'(1));
        cfg_rst_i[0] = 1'b0;
        wait_rel(0, n);
        chk("wait_abort_reload", 64'(n), 64'(17));
        repeat (10) cycle();

`ifdef CC_RST_QUIESCE_EN
        // Reset request waits for the core to go idle
        core_idle_i[0] = 1'b0;
        pulse(0);
        chk("quiesce_low_0", 64'(core_rst_o[0]), 64'(0));
        for (int k = 1; k < 20; k++) begin
            cycle();
            chk("quiesce_low", 64'(core_rst_o[0]), 64'(0));
        end
        core_idle_i[0] = 1'b1;
        cycle();
        chk("quiesce_rise", 64'(core_rst_o[0]), 64'(1));
        wait_rel(0, n);
        repeat (10) cycle();
`endif

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int b;
            b = int'($urandom_range(0, N_CC - 1));
            if ($urandom_range(0, 29) == 0) cfg_rst_i[b] = ~cfg_rst_i[b];
            if ($urandom_range(0, 19) == 0) cfg_boot_i[32*b +: 32] = $urandom();
            core_idle_i = 2'($urandom());
            PRESET = ($urandom_range(0, 399) == 0);
            cycle();
        end
        PRESET = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
